karatsuba_seq: RTL and testbench

Multi-cycle, handshaked N x N multiplier built on one level of Karatsuba decomposition. A single shared N/2 x N/2 unsigned combinational sub-multiplier computes the three partial products P3, P2 and P1 on successive cycles. The block then recombines them and registers the 2N-bit result. It generalises the team's combinational karatsuba core with a valid/ready interface, a selectable signed mode and lower area through sub-multiplier reuse.

---
 rtl/karatsuba_seq.sv | 187 ++++++++++++++++++
 tb/tb_karatsuba_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq.sv
// karatsuba_seq: handshaked N x N multiplier using one Karatsuba level on a single shared N/2 x N/2 sub-multiplier.
// Define KARATSUBA_SEQ_STATS_EN to add the op_count output (completed output handshakes, wrapping).
module karatsuba_seq #(
    parameter int unsigned N      = 16,
    parameter bit          SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] c,
`ifdef KARATSUBA_SEQ_STATS_EN
    output logic [31:0]    op_count,
`endif
    output logic           busy
);

    localparam int unsigned M = N / 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_H,
        MUL_L,
        MUL_M,
        COMBINE,
        DONE
    } state_t;

    state_t         state_q;
    logic [N-1:0]   mag_a_q, mag_b_q;
    logic           neg_q;
    logic [N-1:0]   p3_q, p2_q, p1_q;
    logic           s_q;
    logic [2*N-1:0] c_q;
    logic           in_ready_q, out_valid_q, busy_q;
`ifdef KARATSUBA_SEQ_STATS_EN
    logic [31:0]    op_count_q;
`endif

    // Operand magnitudes and result sign captured on accept.
    logic [N-1:0] mag_a_d, mag_b_d;
    logic         neg_d;

    always_comb begin
        mag_a_d = a;
        mag_b_d = b;
        neg_d   = 1'b0;
        if (SIGNED) begin
            if (a[N-1]) mag_a_d = '0 - a;
            if (b[N-1]) mag_b_d = '0 - b;
            neg_d = a[N-1] ^ b[N-1];
        end
    end

    logic [M-1:0] ah, al, bh, bl;
    assign ah = mag_a_q[N-1:M];
    assign al = mag_a_q[M-1:0];
    assign bh = mag_b_q[N-1:M];
    assign bl = mag_b_q[M-1:0];

    // Middle-term differences; their magnitudes never exceed 2^M-1, so M bits suffice.
    logic [M:0]   am, bm;
    logic [M-1:0] am_abs, bm_abs;

    always_comb begin
        am     = {1'b0, al} - {1'b0, ah};
        bm     = {1'b0, bh} - {1'b0, bl};
        am_abs = am[M] ? (~am[M-1:0] + M'(1)) : am[M-1:0];
        bm_abs = bm[M] ? (~bm[M-1:0] + M'(1)) : bm[M-1:0];
    end

    logic [M-1:0] mul_x, mul_y;
    logic [N-1:0] mul_p;

    always_comb begin
        case (state_q)
            MUL_H: begin
                mul_x = ah;
                mul_y = bh;
            end
            MUL_L: begin
                mul_x = al;
                mul_y = bl;
            end
            default: begin
                mul_x = am_abs;
                mul_y = bm_abs;
            end
        endcase
    end

    assign mul_p = N'(mul_x) * N'(mul_y);

    // Recombination: mid is non-negative, so zero-extension into the 2N-bit sum is exact.
    logic [N+1:0]   mid;
    logic [2*N-1:0] mid_w, prod, c_d;

    always_comb begin
        mid   = {2'b00, p3_q} + {2'b00, p2_q}
              + (s_q ? ('0 - {2'b00, p1_q}) : {2'b00, p1_q});
        mid_w = '0;
        mid_w[N+1:0] = mid;
        prod  = {p3_q, {N{1'b0}}} + (mid_w << M) + {{N{1'b0}}, p2_q};
        c_d   = neg_q ? ('0 - prod) : prod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_q       <= 1'b0;
            p3_q        <= '0;
            p2_q        <= '0;
            p1_q        <= '0;
            s_q         <= 1'b0;
            c_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KARATSUBA_SEQ_STATS_EN
            op_count_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mag_a_q    <= mag_a_d;
                        mag_b_q    <= mag_b_d;
                        neg_q      <= neg_d;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= MUL_H;
                    end
                end
                MUL_H: begin
                    p3_q    <= mul_p;
                    state_q <= MUL_L;
                end
                MUL_L: begin
                    p2_q    <= mul_p;
                    state_q <= MUL_M;
                end
                MUL_M: begin
                    p1_q    <= mul_p;
                    s_q     <= am[M] ^ bm[M];
                    state_q <= COMBINE;
                end
                COMBINE: begin
                    c_q         <= c_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
`ifdef KARATSUBA_SEQ_STATS_EN
                        op_count_q  <= op_count_q + 32'd1;
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign busy      = busy_q;
`ifdef KARATSUBA_SEQ_STATS_EN
    assign op_count  = op_count_q;
`endif

endmodule

// File: tb/tb_karatsuba_seq.sv
// Scoreboard bench for karatsuba_seq: six lanes (N = 16, 2, 32; unsigned and signed) each with driver, model and monitor.
module tb_karatsuba_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  lane;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] e;
    } dir_t;

    localparam dir_t DIRS [4] = '{
        '{3'd0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001},
        '{3'd1, 16'h8000, 16'h8000, 32'h40000000},
        '{3'd1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF},
        '{3'd1, 16'h7FFF, 16'h8000, 32'hC0008000}
    };

    for (genvar g = 0; g < 6; g++) begin : lane
        localparam int unsigned NN = (g < 2) ? 16 : ((g < 4) ? 2 : 32);
        localparam bit          SS = ((g % 2) == 1);

        logic              rst_l     = 1'b1;
        logic              in_valid  = 1'b0;
        logic              out_ready = 1'b1;
        logic [NN-1:0]     a         = '0;
        logic [NN-1:0]     b         = '0;
        logic              in_ready, out_valid, busy;
        logic [2*NN-1:0]   c;
`ifdef KARATSUBA_SEQ_STATS_EN
        logic [31:0]       op_count;
`endif
        int unsigned       or_mode   = 0;
        int unsigned       hs_count  = 0;
        bit                done      = 1'b0;
        logic [2*NN-1:0]   exp_q [$];

        karatsuba_seq #(.N(NN), .SIGNED(SS)) dut (
            .clk       (clk),
            .rst       (rst_l),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .c         (c),
`ifdef KARATSUBA_SEQ_STATS_EN
            .op_count  (op_count),
`endif
            .busy      (busy)
        );

        // Reference: the arithmetic product of the operands read in the lane's number system.
        function automatic logic [2*NN-1:0] model(input logic [NN-1:0] x, input logic [NN-1:0] y);
            logic signed [2*NN-1:0] sx, sy;
            sx = SS ? {{NN{x[NN-1]}}, x} : {{NN{1'b0}}, x};
            sy = SS ? {{NN{y[NN-1]}}, y} : {{NN{1'b0}}, y};
            return sx * sy;
        endfunction

        task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL lane%0d %s actual=%0h required=%0h", g, nm, act, ex);
            end
        endtask

        task automatic tmo(input string nm);
            checks++;
            failures++;
            $display("FAIL lane%0d %s actual=timeout required=completion", g, nm);
        endtask

        task automatic issue(input logic [NN-1:0] x, input logic [NN-1:0] y, input logic [2*NN-1:0] e);
            int unsigned w = 0;
            a        = x;
            b        = y;
            in_valid = 1'b1;
            while (!in_ready && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            if (!in_ready) begin
                tmo("accept");
                in_valid = 1'b0;
                return;
            end
            exp_q.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("busy_after_accept", busy, 1);
            chk("in_ready_after_accept", in_ready, 0);
            chk("latency0", out_valid, 0);
            for (int i = 1; i <= 4; i++) begin
                @(posedge clk); #1;
                chk("latency", out_valid, (i == 4));
            end
        endtask

        task automatic drain();
            int unsigned w = 0;
            or_mode = 0;
            while (exp_q.size() != 0 && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            if (exp_q.size() != 0) tmo("drain");
            @(posedge clk); #1;
        endtask

        always @(posedge clk) begin
            #2;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end

        // Monitor: pops the scoreboard on each output handshake and polices backpressure.
        logic [2*NN-1:0] held_c;
        bit              held    = 1'b0;
        bit              hs_prev = 1'b0;

        always @(negedge clk) begin
            if (rst_l) begin
                held     = 1'b0;
                hs_prev  = 1'b0;
                hs_count = 0;
            end else begin
                chk("busy_vs_in_ready", busy, !in_ready);
                if (hs_prev) begin
                    chk("in_ready_after_hs", in_ready, 1);
                    chk("out_valid_drop", out_valid, 0);
                end
                if (held) begin
                    chk("out_valid_held", out_valid, 1);
                    chk("c_stable_bp", c, held_c);
                end
                hs_prev = 1'b0;
                held    = 1'b0;
                if (out_valid) begin
                    chk("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL lane%0d unexpected_output actual=%0h required=none", g, c);
                        end else begin
                            chk("product", c, exp_q.pop_front());
                        end
`ifdef KARATSUBA_SEQ_STATS_EN
                        chk("op_count", op_count, hs_count);
`endif
                        hs_count++;
                        hs_prev = 1'b1;
                    end else begin
                        held   = 1'b1;
                        held_c = c;
                    end
                end
            end
        end

        initial begin : drive
            logic [NN-1:0]   z, o, mn, mx, ra, rb;
            logic [2*NN-1:0] bp_e;
            int unsigned     w, hs0;
            z  = '0;
            o  = '1;
            mn = '0;
            mn[NN-1] = 1'b1;
            mx = ~mn;

            repeat (3) begin @(posedge clk); #1; end
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_c", c, 0);
            chk("rst_busy", busy, 0);
`ifdef KARATSUBA_SEQ_STATS_EN
            chk("rst_op_count", op_count, 0);
`endif
            rst_l = 1'b0;
            @(posedge clk); #1;

            for (int i = 0; i < 4; i++)
                if (int'(DIRS[i].lane) == g)
                    issue(NN'(DIRS[i].a), NN'(DIRS[i].b), (2*NN)'(DIRS[i].e));

            issue(z, z, model(z, z));
            issue(o, o, model(o, o));
            issue(mn, mn, model(mn, mn));
            issue(mx, mx, model(mx, mx));
            issue(mn, mx, model(mn, mx));
            issue(mx, mn, model(mx, mn));
            issue(z, o, model(z, o));
            issue(o, z, model(o, z));

            // Output held off for 5 cycles while a new pair waits on the inputs.
            drain();
            or_mode = 2;
            repeat (2) begin @(posedge clk); #1; end
            bp_e = model(o, o);
            issue(o, o, bp_e);
            a        = mn;
            b        = o;
            in_valid = 1'b1;
            hs0      = hs_count;
            repeat (5) begin
                @(posedge clk); #1;
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_c", c, bp_e);
            end
            or_mode = 0;
            issue(mn, o, model(mn, o));
            chk("bp_one_handshake", hs_count - hs0, 1);

            // Reset asserted while the operation sits in MUL_L.
            drain();
            a        = NN'(3);
            b        = NN'(5);
            in_valid = 1'b1;
            w        = 0;
            while (!in_ready && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            if (!in_ready) tmo("accept_before_reset");
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst_l = 1'b1;
            #1;
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_c", c, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_in_ready", in_ready, 1);
            exp_q.delete();
            @(posedge clk); #1;
            rst_l = 1'b0;
            issue(NN'(3), NN'(5), model(NN'(3), NN'(5)));

            or_mode = 1;
            for (int i = 0; i < 2000; i++) begin
                ra = NN'($urandom);
                rb = NN'($urandom);
                issue(ra, rb, model(ra, rb));
                if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            drain();
            done = 1'b1;
        end
    end

    initial begin
        int unsigned cyc = 0;
        while (!(lane[0].done && lane[1].done && lane[2].done &&
                 lane[3].done && lane[4].done && lane[5].done) && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(lane[0].done && lane[1].done && lane[2].done &&
              lane[3].done && lane[4].done && lane[5].done)) begin
            checks++;
            failures++;
            $display("FAIL run_complete actual=timeout required=all lanes done");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
